vector_opbuff_mc: RTL and testbench

Parametrised multi-channel operand buffer between the vector register file (veggie) read ports and the lanes. It is the successor to the single operand buffer. Each of NUM_CH read channels gets its own DEPTH-entry FIFO. A descriptor FIFO records which channels each instruction needs. An operand bundle is issued to the lanes only when every required channel has data at its head. Tags are cross-checked at issue, and a flush discards all in-flight operands.

---
 rtl/vector_pkg.sv | 44 ++++
 rtl/opbuff_fifo.sv | 57 +++++
 rtl/vector_opbuff_mc.sv | 128 ++++++++++++
 tb/tb_vector_opbuff_mc.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared parameters and bundle types for the multi-channel operand buffer.
package vector_pkg;

    localparam int OPB_NUM_CH       = 3;
    localparam int OPB_DEPTH        = 4;
    localparam int OPB_NUM_ELEMENTS = 32;
    localparam int OPB_ELEM_W       = 16;
    localparam int OPB_TAG_W        = 6;
    localparam int OPB_VEC_W        = OPB_NUM_ELEMENTS * OPB_ELEM_W;

    // One descriptor: which channels an instruction consumes.
    typedef struct packed {
        logic [OPB_NUM_CH-1:0] mask;
    } opbuff_desc_t;

    // One operand FIFO entry.
    typedef struct packed {
        logic [OPB_VEC_W-1:0] data;
        logic [OPB_TAG_W-1:0] tag;
    } opbuff_entry_t;

    // Inputs of the buffer, grouped for the vector interface bundle.
    typedef struct packed {
        logic [OPB_NUM_CH-1:0]           in_valid;
        logic [OPB_NUM_CH*OPB_VEC_W-1:0] in_data;
        logic [OPB_NUM_CH*OPB_TAG_W-1:0] in_tag;
        logic                            desc_valid;
        logic [OPB_NUM_CH-1:0]           desc_mask;
        logic                            out_ready;
    } opbuff_mc_in_t;

    // Outputs of the buffer, grouped for the vector interface bundle.
    typedef struct packed {
        logic [OPB_NUM_CH-1:0]           in_ready;
        logic                            desc_ready;
        logic                            out_valid;
        logic [OPB_NUM_CH*OPB_VEC_W-1:0] out_data;
        logic [OPB_NUM_CH-1:0]           out_mask;
        logic [OPB_TAG_W-1:0]            out_tag;
        logic                            tag_err;
        logic                            accomplished;
    } opbuff_mc_out_t;

endpackage

// File: rtl/opbuff_fifo.sv
// Generic registered FIFO (no fall-through) with synchronous reset and flush.
// A push while full and a pop while empty are ignored.
module opbuff_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // full does not credit a same-cycle pop, so a full FIFO never accepts
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign rdata   = mem[rd_ptr];

    // Storage write; flushed or reset cycles drop the incoming word
    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keep count
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vector_opbuff_mc.sv
// Multi-channel operand buffer: one operand FIFO per VRF read channel plus a
// descriptor FIFO. A bundle issues once every channel named by the head
// descriptor has an operand at its head.
module vector_opbuff_mc
    import vector_pkg::*;
#(
    parameter int NUM_CH       = OPB_NUM_CH,
    parameter int DEPTH        = OPB_DEPTH,
    parameter int NUM_ELEMENTS = OPB_NUM_ELEMENTS,
    parameter int ELEM_W       = OPB_ELEM_W,
    parameter int TAG_W        = OPB_TAG_W
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             flush,
    input  logic [NUM_CH-1:0]                in_valid,
    input  logic [NUM_CH*NUM_ELEMENTS*ELEM_W-1:0] in_data,
    input  logic [NUM_CH*TAG_W-1:0]          in_tag,
    output logic [NUM_CH-1:0]                in_ready,
    input  logic                             desc_valid,
    input  logic [NUM_CH-1:0]                desc_mask,
    output logic                             desc_ready,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_CH*NUM_ELEMENTS*ELEM_W-1:0] out_data,
    output logic [NUM_CH-1:0]                out_mask,
    output logic [TAG_W-1:0]                 out_tag,
    output logic                             tag_err,
    output logic                             accomplished
);

    localparam int VEC_W = NUM_ELEMENTS * ELEM_W;
    localparam int ENT_W = VEC_W + TAG_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [ENT_W-1:0]  ch_head  [NUM_CH];
    logic [CW-1:0]     ch_count [NUM_CH];
    logic [NUM_CH-1:0] ch_full;
    logic [NUM_CH-1:0] ch_pop;
    logic [NUM_CH-1:0] head_mask;
    logic [CW-1:0]     desc_count;
    logic              desc_full;
    logic              fire;
    logic              mismatch;
    logic              ops_ok;
    logic              found;
    logic [TAG_W-1:0]  ref_tag;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        opbuff_fifo #(
            .DEPTH (DEPTH),
            .W     (ENT_W)
        ) u_ch_fifo (
            .clk   (CLK),
            .rst   (RST),
            .flush (flush),
            .push  (in_valid[c]),
            .pop   (ch_pop[c]),
            .wdata ({in_data[c*VEC_W +: VEC_W], in_tag[c*TAG_W +: TAG_W]}),
            .rdata (ch_head[c]),
            .full  (ch_full[c]),
            .count (ch_count[c])
        );
    end

    opbuff_fifo #(
        .DEPTH (DEPTH),
        .W     (NUM_CH)
    ) u_desc_fifo (
        .clk   (CLK),
        .rst   (RST),
        .flush (flush),
        .push  (desc_valid),
        .pop   (fire),
        .wdata (desc_mask),
        .rdata (head_mask),
        .full  (desc_full),
        .count (desc_count)
    );

    assign in_ready   = ~ch_full;
    assign desc_ready = !desc_full;

    // Issue gating, tag cross-check and output muxing of the head bundle
    always_comb begin
        ops_ok   = 1'b1;
        found    = 1'b0;
        mismatch = 1'b0;
        ref_tag  = '0;
        out_data = '0;
        out_mask = '0;
        out_tag  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (head_mask[c]) begin
                if (ch_count[c] == '0) ops_ok = 1'b0;
                if (!found) begin
                    ref_tag = ch_head[c][TAG_W-1:0];
                    found   = 1'b1;
                end else if (ch_head[c][TAG_W-1:0] != ref_tag) begin
                    mismatch = 1'b1;
                end
            end
        end
        out_valid = (desc_count != '0) && ops_ok;
        // flush wins over issue so nothing leaves during a discard
        fire      = out_valid && out_ready && !flush;
        ch_pop    = fire ? head_mask : '0;
        if (out_valid) begin
            out_mask = head_mask;
            out_tag  = ref_tag;
            for (int c = 0; c < NUM_CH; c++) begin
                if (head_mask[c]) out_data[c*VEC_W +: VEC_W] = ch_head[c][ENT_W-1:TAG_W];
            end
        end
    end

    // Issue pulse and sticky tag error; flush leaves tag_err untouched
    always_ff @(posedge CLK) begin
        if (RST) begin
            accomplished <= 1'b0;
            tag_err      <= 1'b0;
        end else begin
            accomplished <= fire && !flush;
            if (fire && mismatch) tag_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vector_opbuff_mc.sv
// Self-checking bench for vector_opbuff_mc using a queue-based reference model.
module tb_vector_opbuff_mc;

    localparam int NCH  = 3;
    localparam int DEP  = 4;
    localparam int VW   = 512;
    localparam int TW   = 6;

    typedef struct packed {
        logic [15:0] elem;
        logic [5:0]  tag;
    } ent_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic              flush;
    logic [NCH-1:0]    in_valid;
    logic [NCH*VW-1:0] in_data;
    logic [NCH*TW-1:0] in_tag;
    logic [NCH-1:0]    in_ready;
    logic              desc_valid;
    logic [NCH-1:0]    desc_mask;
    logic              desc_ready;
    logic              out_valid;
    logic              out_ready;
    logic [NCH*VW-1:0] out_data;
    logic [NCH-1:0]    out_mask;
    logic [TW-1:0]     out_tag;
    logic              tag_err;
    logic              accomplished;

    int   checks = 0;
    int   fails  = 0;
    ent_t mq [NCH][$];
    logic [NCH-1:0] dq [$];
    logic exp_tag_err = 1'b0;

    vector_opbuff_mc dut (
        .CLK          (CLK),
        .RST          (RST),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_tag       (in_tag),
        .in_ready     (in_ready),
        .desc_valid   (desc_valid),
        .desc_mask    (desc_mask),
        .desc_ready   (desc_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_mask     (out_mask),
        .out_tag      (out_tag),
        .tag_err      (tag_err),
        .accomplished (accomplished)
    );

    always #5 CLK = ~CLK;

    // Drive one channel write this cycle; model accepts it only if not full
    task automatic push_ch(input int c, input logic [5:0] tag, input logic [15:0] elem);
        in_valid[c]          = 1'b1;
        in_data[c*VW +: VW]  = {32{elem}};
        in_tag[c*TW +: TW]   = tag;
        if (mq[c].size() < DEP) mq[c].push_back('{elem: elem, tag: tag});
    endtask

    task automatic push_desc(input logic [NCH-1:0] m);
        desc_valid = 1'b1;
        desc_mask  = m;
        if (dq.size() < DEP) dq.push_back(m);
    endtask

    // Advance one clock; model state follows flush/reset at the edge
    task automatic step();
        @(posedge CLK);
        if (RST || flush) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            dq.delete();
            if (RST) exp_tag_err = 1'b0;
        end
        #1;
        in_valid   = '0;
        desc_valid = 1'b0;
        flush      = 1'b0;
    endtask

    // Scoreboard: compare the presented bundle to the model head, pop on fire
    task automatic sb_compare(input string name);
        logic [NCH-1:0] m;
        logic [5:0]     etag;
        logic [VW-1:0]  evec;
        bit             found;
        bit             mm;
        checks++;
        if (dq.size() == 0) begin
            fails++;
            $display("FAIL %s: no expected bundle queued", name);
            return;
        end
        m = dq[0];
        found = 0;
        mm = 0;
        etag = '0;
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) begin
                if (mq[c].size() == 0) begin
                    fails++;
                    $display("FAIL %s: model has no operand for ch%0d", name, c);
                    return;
                end
                if (!found) begin
                    etag = mq[c][0].tag;
                    found = 1;
                end else if (mq[c][0].tag != etag) begin
                    mm = 1;
                end
            end
        end
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s out_valid: got %b expected 1", name, out_valid);
        end
        checks++;
        if (out_mask !== m) begin
            fails++;
            $display("FAIL %s out_mask: got %b expected %b", name, out_mask, m);
        end
        checks++;
        if (out_tag !== etag) begin
            fails++;
            $display("FAIL %s out_tag: got %0d expected %0d", name, out_tag, etag);
        end
        for (int c = 0; c < NCH; c++) begin
            evec = m[c] ? {32{mq[c][0].elem}} : '0;
            checks++;
            if (out_data[c*VW +: VW] !== evec) begin
                fails++;
                $display("FAIL %s out_data ch%0d: got %h expected %h", name, c,
                         out_data[c*VW +: VW][63:0], evec[63:0]);
            end
        end
        if (out_ready && !flush) begin
            void'(dq.pop_front());
            for (int c = 0; c < NCH; c++) if (m[c]) void'(mq[c].pop_front());
            if (mm) exp_tag_err = 1'b1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 3'b111) begin fails++; $display("FAIL reset in_ready: got %b expected 111", in_ready); end
        checks++;
        if (desc_ready !== 1'b1) begin fails++; $display("FAIL reset desc_ready: got %b expected 1", desc_ready); end
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_data !== '0) begin fails++; $display("FAIL reset out_data: got nonzero expected 0"); end
        checks++;
        if (out_mask !== 3'b000 || out_tag !== 6'd0) begin
            fails++; $display("FAIL reset out_mask/out_tag: got %b/%0d expected 000/0", out_mask, out_tag);
        end
        checks++;
        if (tag_err !== 1'b0 || accomplished !== 1'b0) begin
            fails++; $display("FAIL reset tag_err/accomplished: got %b/%b expected 0/0", tag_err, accomplished);
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_basic_issue();
        out_ready = 1'b1;
        push_desc(3'b011);
        push_ch(0, 6'd5, 16'h3C00);
        push_ch(1, 6'd5, 16'h4000);
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL basic early out_valid: got %b expected 0", out_valid); end
        step();
        sb_compare("basic");
        checks++;
        if (accomplished !== 1'b0) begin fails++; $display("FAIL basic pre accomplished: got %b expected 0", accomplished); end
        step();
        checks++;
        if (accomplished !== 1'b1) begin fails++; $display("FAIL basic accomplished: got %b expected 1", accomplished); end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 3'b111 || desc_ready !== 1'b1) begin
            fails++; $display("FAIL basic drained: got v=%b ir=%b dr=%b expected 0/111/1", out_valid, in_ready, desc_ready);
        end
        step();
        checks++;
        if (accomplished !== 1'b0) begin fails++; $display("FAIL basic pulse width: got %b expected 0", accomplished); end
    endtask

    task automatic test_partial_arrival();
        out_ready = 1'b1;
        push_desc(3'b111);
        push_ch(0, 6'd10, 16'h1111);
        push_ch(1, 6'd10, 16'h2222);
        step();
        for (int cyc = 1; cyc <= 3; cyc++) begin
            if (cyc == 3) push_ch(2, 6'd10, 16'h3333);
            checks++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL partial cycle %0d out_valid: got %b expected 0", cyc, out_valid); end
            step();
        end
        sb_compare("partial");
        step();
        checks++;
        if (accomplished !== 1'b1) begin fails++; $display("FAIL partial accomplished: got %b expected 1", accomplished); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            push_ch(0, 6'(i), 16'h0100 + 16'(i));
            step();
        end
        checks++;
        if (in_ready !== 3'b110) begin fails++; $display("FAIL full in_ready: got %b expected 110", in_ready); end
        push_ch(0, 6'd4, 16'h0104);
        step();
        checks++;
        if (in_ready !== 3'b110) begin fails++; $display("FAIL overfill in_ready: got %b expected 110", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) push_desc(3'b001);
            if (k >= 2 && k <= 5) push_ch(0, 6'(10 + k - 2), 16'h0200 + 16'(k));
            if (k == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b no desc out_valid: got %b expected 0", out_valid); end
            end else begin
                sb_compare("b2b");
            end
            if (k == 1) begin
                checks++;
                if (in_ready[0] !== 1'b0) begin fails++; $display("FAIL b2b no pop credit: got %b expected 0", in_ready[0]); end
            end
            if (k == 2) begin
                checks++;
                if (in_ready[0] !== 1'b1) begin fails++; $display("FAIL b2b steady in_ready: got %b expected 1", in_ready[0]); end
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 3'b111 || desc_ready !== 1'b1) begin
            fails++; $display("FAIL b2b drained: got v=%b ir=%b dr=%b expected 0/111/1", out_valid, in_ready, desc_ready);
        end
    endtask

    task automatic test_tag_mismatch();
        out_ready = 1'b1;
        push_desc(3'b101);
        push_ch(0, 6'd7, 16'h1234);
        push_ch(2, 6'd9, 16'h5678);
        step();
        checks++;
        if (tag_err !== 1'b0) begin fails++; $display("FAIL mismatch pre tag_err: got %b expected 0", tag_err); end
        sb_compare("mismatch");
        step();
        checks++;
        if (tag_err !== 1'b1) begin fails++; $display("FAIL mismatch tag_err: got %b expected 1", tag_err); end
        checks++;
        if (accomplished !== 1'b1) begin fails++; $display("FAIL mismatch accomplished: got %b expected 1", accomplished); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push_desc(3'b010);
        push_ch(1, 6'd20, 16'hA000);
        step();
        push_desc(3'b010);
        push_ch(1, 6'd21, 16'hA001);
        step();
        push_ch(1, 6'd22, 16'hA002);
        step();
        flush = 1'b1;
        out_ready = 1'b1;
        push_ch(1, 6'd23, 16'hA003);
        push_desc(3'b010);
        checks++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL flush cycle out_valid: got %b expected 1", out_valid); end
        step();
        checks++;
        if (in_ready !== 3'b111 || desc_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL flush cleared: got ir=%b dr=%b v=%b expected 111/1/0", in_ready, desc_ready, out_valid);
        end
        checks++;
        if (accomplished !== 1'b0) begin fails++; $display("FAIL flush fire suppressed: got %b expected 0", accomplished); end
        checks++;
        if (tag_err !== exp_tag_err) begin fails++; $display("FAIL flush sticky tag_err: got %b expected %b", tag_err, exp_tag_err); end
        push_desc(3'b010);
        push_ch(1, 6'd30, 16'hB000);
        step();
        sb_compare("post_flush");
        step();
        checks++;
        if (accomplished !== 1'b1) begin fails++; $display("FAIL post flush accomplished: got %b expected 1", accomplished); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        push_desc(3'b011);
        push_ch(0, 6'd40, 16'hC000);
        step();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        push_ch(1, 6'd40, 16'hC001);
        step();
        checks++;
        if (tag_err !== 1'b0) begin fails++; $display("FAIL reset clears tag_err: got %b expected 0", tag_err); end
        checks++;
        if (out_valid !== 1'b0 || accomplished !== 1'b0) begin
            fails++; $display("FAIL reset mid bundle: got v=%b acc=%b expected 0/0", out_valid, accomplished);
        end
        checks++;
        if (in_ready !== 3'b111) begin fails++; $display("FAIL reset mid in_ready: got %b expected 111", in_ready); end
    endtask

    initial begin
        RST        = 1'b1;
        flush      = 1'b0;
        in_valid   = '0;
        in_data    = '0;
        in_tag     = '0;
        desc_valid = 1'b0;
        desc_mask  = '0;
        out_ready  = 1'b0;
        test_reset();
        test_basic_issue();
        test_partial_arrival();
        test_back_to_back();
        test_tag_mismatch();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
